// File: rtl/uart_alu_requester_pkg.sv
// Shared widths and one-hot state encoding for the UART ALU link requester.
package uart_alu_requester_pkg;

   localparam int WIDTH_WORD             = 8;
   localparam int CANT_DATOS_ENTRADA_ALU = 8;
   localparam int CANT_BITS_OPCODE_ALU   = 8;
   localparam int CANT_DATOS_SALIDA_ALU  = 8;

   typedef enum logic [7:0] {
      ST_IDLE     = 8'b0000_0001,
      ST_SEND_A   = 8'b0000_0010,
      ST_WAIT_A   = 8'b0000_0100,
      ST_SEND_OP  = 8'b0000_1000,
      ST_WAIT_OP  = 8'b0001_0000,
      ST_SEND_B   = 8'b0010_0000,
      ST_WAIT_B   = 8'b0100_0000,
      ST_WAIT_RES = 8'b1000_0000
   } state_t;

   function automatic logic is_wait(state_t s);
      return s inside {ST_WAIT_A, ST_WAIT_OP, ST_WAIT_B, ST_WAIT_RES};
   endfunction

endpackage

// File: rtl/uart_alu_requester_if.sv
// Request, UART transmitter and UART receiver signals seen by the requester.
interface uart_alu_requester_if #(
   parameter int WIDTH_WORD             = uart_alu_requester_pkg::WIDTH_WORD,
   parameter int CANT_DATOS_ENTRADA_ALU = uart_alu_requester_pkg::CANT_DATOS_ENTRADA_ALU,
   parameter int CANT_BITS_OPCODE_ALU   = uart_alu_requester_pkg::CANT_BITS_OPCODE_ALU,
   parameter int CANT_DATOS_SALIDA_ALU  = uart_alu_requester_pkg::CANT_DATOS_SALIDA_ALU
);

   logic                              i_start;
   logic [CANT_DATOS_ENTRADA_ALU-1:0] i_dato_A;
   logic [CANT_DATOS_ENTRADA_ALU-1:0] i_dato_B;
   logic [CANT_BITS_OPCODE_ALU-1:0]   i_opcode;
   logic                              o_busy;
   logic                              o_tx_start;
   logic [WIDTH_WORD-1:0]             o_data_tx;
   logic                              i_tx_done;
   logic [WIDTH_WORD-1:0]             i_data_rx;
   logic                              i_rx_done;
   logic [CANT_DATOS_SALIDA_ALU-1:0]  o_resultado;
   logic                              o_result_valid;
   logic                              o_timeout;

   modport master (
      input  i_start, i_dato_A, i_dato_B, i_opcode, i_tx_done, i_data_rx, i_rx_done,
      output o_busy, o_tx_start, o_data_tx, o_resultado, o_result_valid, o_timeout
   );

   modport slave (
      output i_start, i_dato_A, i_dato_B, i_opcode, i_tx_done, i_data_rx, i_rx_done,
      input  o_busy, o_tx_start, o_data_tx, o_resultado, o_result_valid, o_timeout
   );

endinterface

// File: rtl/uart_alu_requester_watchdog_counter.sv
// Wait-state watchdog: down-counter reloaded on clear, expired at terminal count.
module watchdog_counter #(
   parameter int CANT_BITS_TIMEOUT = 20,
   parameter int TIMEOUT_CYCLES    = 1000000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CANT_BITS_TIMEOUT-1:0] LOAD = CANT_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [CANT_BITS_TIMEOUT-1:0] count;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         count <= LOAD;
      end else if (clear) begin
         count <= LOAD;
      end else if (enable && (count != '0)) begin
         count <= count - CANT_BITS_TIMEOUT'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/uart_alu_requester.sv
// Host-side UART ALU initiator: sends A, opcode, B as three UART words, then waits for the result word.
//  state       | meaning
//  ST_IDLE     | waiting for i_start, request latched on acceptance
//  ST_SEND_A   | issue tx_start with operand A
//  ST_WAIT_A   | wait tx_done for A
//  ST_SEND_OP  | issue tx_start with opcode
//  ST_WAIT_OP  | wait tx_done for opcode
//  ST_SEND_B   | issue tx_start with operand B
//  ST_WAIT_B   | wait tx_done for B
//  ST_WAIT_RES | wait rx_done carrying the ALU result
module uart_alu_requester #(
   parameter int WIDTH_WORD             = uart_alu_requester_pkg::WIDTH_WORD,
   parameter int CANT_DATOS_ENTRADA_ALU = uart_alu_requester_pkg::CANT_DATOS_ENTRADA_ALU,
   parameter int CANT_BITS_OPCODE_ALU   = uart_alu_requester_pkg::CANT_BITS_OPCODE_ALU,
   parameter int CANT_DATOS_SALIDA_ALU  = uart_alu_requester_pkg::CANT_DATOS_SALIDA_ALU,
   parameter int CANT_BITS_TIMEOUT      = 20,
   parameter int TIMEOUT_CYCLES         = 1000000
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   uart_alu_requester_if.master bus
);

   import uart_alu_requester_pkg::*;

   state_t                            state;
   state_t                            state_next;
   logic [CANT_DATOS_ENTRADA_ALU-1:0] dato_a_q;
   logic [CANT_DATOS_ENTRADA_ALU-1:0] dato_b_q;
   logic [CANT_BITS_OPCODE_ALU-1:0]   opcode_q;
   logic [CANT_DATOS_SALIDA_ALU-1:0]  res_cap;
   logic                              res_pend;
   logic                              to_pend;
   logic                              strobe;
   logic                              abort;
   logic                              wd_clear;
   logic                              wd_enable;
   logic                              wd_expired;

   // The awaited strobe is resolved before the watchdog, so a strobe on the expiry cycle wins.
   always_comb begin
      state_next = state;
      strobe     = 1'b0;
      case (state)
         ST_IDLE:     if (bus.i_start) state_next = ST_SEND_A;
         ST_SEND_A:   state_next = ST_WAIT_A;
         ST_WAIT_A:   begin strobe = bus.i_tx_done; if (strobe) state_next = ST_SEND_OP;  end
         ST_SEND_OP:  state_next = ST_WAIT_OP;
         ST_WAIT_OP:  begin strobe = bus.i_tx_done; if (strobe) state_next = ST_SEND_B;   end
         ST_SEND_B:   state_next = ST_WAIT_B;
         ST_WAIT_B:   begin strobe = bus.i_tx_done; if (strobe) state_next = ST_WAIT_RES; end
         ST_WAIT_RES: begin strobe = bus.i_rx_done; if (strobe) state_next = ST_IDLE;     end
         default:     state_next = ST_IDLE;
      endcase
      abort = is_wait(state) && !strobe && wd_expired;
      if (abort) state_next = ST_IDLE;
   end

   assign wd_clear  = (state_next != state);
   assign wd_enable = is_wait(state);

   watchdog_counter #(
      .CANT_BITS_TIMEOUT (CANT_BITS_TIMEOUT),
      .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Outputs are registered from the current state, so they trail the state register by one cycle.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state              <= ST_IDLE;
         dato_a_q           <= '0;
         dato_b_q           <= '0;
         opcode_q           <= '0;
         res_cap            <= '0;
         res_pend           <= 1'b0;
         to_pend            <= 1'b0;
         bus.o_busy         <= 1'b0;
         bus.o_tx_start     <= 1'b0;
         bus.o_data_tx      <= '0;
         bus.o_resultado    <= '0;
         bus.o_result_valid <= 1'b0;
         bus.o_timeout      <= 1'b0;
      end else begin
         state <= state_next;
         if ((state == ST_IDLE) && bus.i_start) begin
            dato_a_q <= bus.i_dato_A;
            dato_b_q <= bus.i_dato_B;
            opcode_q <= bus.i_opcode;
         end
         if ((state == ST_WAIT_RES) && bus.i_rx_done) begin
            res_cap <= bus.i_data_rx[CANT_DATOS_SALIDA_ALU-1:0];
         end
         res_pend <= (state == ST_WAIT_RES) && bus.i_rx_done;
         to_pend  <= abort;

         bus.o_busy     <= (state != ST_IDLE);
         bus.o_tx_start <= state inside {ST_SEND_A, ST_SEND_OP, ST_SEND_B};
         case (state)
            ST_SEND_A:  bus.o_data_tx <= WIDTH_WORD'(dato_a_q);
            ST_SEND_OP: bus.o_data_tx <= WIDTH_WORD'(opcode_q);
            ST_SEND_B:  bus.o_data_tx <= WIDTH_WORD'(dato_b_q);
            default:    bus.o_data_tx <= bus.o_data_tx;
         endcase
         bus.o_result_valid <= res_pend;
         if (res_pend) bus.o_resultado <= res_cap;
         bus.o_timeout <= to_pend;
      end
   end

endmodule
